seven_seg_scan_ctrl: RTL and testbench

- Refresh scheduler for a multiplexed N-digit common-anode seven-segment display.
- Time-shares one segment bus between NUM_DIGITS digits. Each digit gets a fixed dwell slot, separated by blanking gaps that suppress ghosting.
- Host writes digit patterns through a valid/ready port into a shadow buffer. A commit copies the shadow buffer to the active buffer at a frame boundary, so the display never tears.
- Sits between the display-value logic and the display pins. Generalises the two-digit alternating driver.

---
 rtl/seven_seg_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed N-digit seven-segment refresh scheduler with shadow/active buffers and tear-free commit.
// Optional per-digit PWM dimming is enabled by defining SEVEN_SEG_BRIGHTNESS_PWM_EN.
module seven_seg_scan_ctrl #(
  parameter  int NUM_DIGITS = 4,
  parameter  int DWELL      = 40000,
  parameter  int BLANK      = 16,
  parameter  int CBITS      = 16,
  localparam int AW         = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [6:0]            wr_data,
  input  logic                  commit,
  output logic                  commit_pending,
  output logic [6:0]            segment,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_tick
`ifdef SEVEN_SEG_BRIGHTNESS_PWM_EN
  ,
  input  logic [3:0]            brightness
`endif
);

  typedef enum logic [1:0] {S_OFF = 2'd0, S_BLANK = 2'd1, S_DRIVE = 2'd2} state_t;

  localparam logic [CBITS-1:0] CNT_ONE    = CBITS'(1);
  localparam logic [CBITS-1:0] BLANK_LAST = CBITS'(BLANK - 1);
  localparam logic [CBITS-1:0] DWELL_LAST = CBITS'(DWELL - 1);
  localparam logic [AW-1:0]    IDX_ONE    = AW'(1);
  localparam logic [AW-1:0]    IDX_LAST   = AW'(NUM_DIGITS - 1);
  // With no blanking every slot boundary lands straight in DRIVE.
  localparam state_t           FIRST_SLOT = (BLANK == 0) ? S_DRIVE : S_BLANK;

  state_t                  state_r, state_n;
  logic [CBITS-1:0]        cnt_r, cnt_n;
  logic [AW-1:0]           idx_r, idx_n;
  logic                    pending_r, pending_n;
  logic                    wrap_s, apply_s, wr_fire_s;
  logic [6:0]              shadow_r [NUM_DIGITS];
  logic [6:0]              active_r [NUM_DIGITS];
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   dig_n;
  logic                    tick_n;

  // Next-state, slot counter and digit index sequencing.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    idx_n   = idx_r;
    wrap_s  = 1'b0;
    if (!en) begin
      state_n = S_OFF;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      case (state_r)
        S_OFF: begin
          state_n = FIRST_SLOT;
          cnt_n   = '0;
          idx_n   = '0;
        end
        S_BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            state_n = S_DRIVE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_r + CNT_ONE;
          end
        end
        S_DRIVE: begin
          if (cnt_r == DWELL_LAST) begin
            state_n = FIRST_SLOT;
            cnt_n   = '0;
            if (idx_r == IDX_LAST) begin
              idx_n  = '0;
              wrap_s = 1'b1;
            end else begin
              idx_n = idx_r + IDX_ONE;
            end
          end else begin
            cnt_n = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_n = S_OFF;
          cnt_n   = '0;
          idx_n   = '0;
        end
      endcase
    end
  end

  // Commit bookkeeping and next registered output values.
  always_comb begin
    apply_s   = pending_r && ((state_r == S_OFF) || wrap_s);
    wr_fire_s = wr_valid && wr_ready && (int'(wr_addr) < NUM_DIGITS);
    if (apply_s) begin
      pending_n = 1'b0;
    end else if (commit) begin
      pending_n = 1'b1;
    end else begin
      pending_n = pending_r;
    end
    seg_n  = 7'd0;
    dig_n  = '0;
    tick_n = 1'b0;
    if (state_n == S_DRIVE) begin
      // The digit entered on a wrap edge must already see the new frame.
      seg_n  = apply_s ? shadow_r[idx_n] : active_r[idx_n];
      tick_n = (idx_n == '0) && (cnt_n == '0);
`ifdef SEVEN_SEG_BRIGHTNESS_PWM_EN
      if (cnt_n[3:0] <= brightness) begin
        dig_n[idx_n] = 1'b1;
      end else begin
        dig_n = '0;
      end
`else
      dig_n[idx_n] = 1'b1;
`endif
    end else begin
      seg_n = 7'd0;
    end
  end

  // Scan state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_OFF;
      cnt_r     <= '0;
      idx_r     <= '0;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      idx_r     <= idx_n;
      pending_r <= pending_n;
    end
  end

  // Shadow and active pattern buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r <= '{default: 7'd0};
      active_r <= '{default: 7'd0};
    end else begin
      if (wr_fire_s) begin
        shadow_r[wr_addr] <= wr_data;
      end
      if (apply_s) begin
        active_r <= shadow_r;
      end
    end
  end

  // Registered display and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      segment        <= 7'd0;
      digit_en       <= '0;
      frame_tick     <= 1'b0;
      commit_pending <= 1'b0;
      wr_ready       <= 1'b1;
    end else begin
      segment        <= seg_n;
      digit_en       <= dig_n;
      frame_tick     <= tick_n;
      commit_pending <= pending_n;
      wr_ready       <= !pending_n;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed self-checking bench for seven_seg_scan_ctrl: scan order, tear-free commit,
// disable/reset mid-slot, zero blanking, out-of-range writes, and PWM when enabled.
module tb_seven_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, wr_valid, commit;
  logic [1:0] wr_addr;
  logic [6:0] wr_data;
  logic       wr_ready, commit_pending, frame_tick;
  logic [6:0] segment;
  logic [3:0] digit_en;

  logic       b_en, b_wr_valid, b_commit;
  logic [1:0] b_wr_addr;
  logic [6:0] b_wr_data;
  logic       b_rdy, b_pend, b_tick;
  logic [6:0] b_seg;
  logic [2:0] b_den;

  int errors = 0;
  int checks = 0;
  int k;
  logic [6:0] m_shadow [4];
  logic [6:0] m_act    [4];
  logic       m_pend;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL(8), .BLANK(2), .CBITS(8)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit), .commit_pending(commit_pending),
    .segment(segment), .digit_en(digit_en), .frame_tick(frame_tick)
`ifdef SEVEN_SEG_BRIGHTNESS_PWM_EN
    , .brightness(4'd15)
`endif
  );

  seven_seg_scan_ctrl #(.NUM_DIGITS(3), .DWELL(4), .BLANK(0), .CBITS(8)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .wr_valid(b_wr_valid), .wr_ready(b_rdy),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data), .commit(b_commit), .commit_pending(b_pend),
    .segment(b_seg), .digit_en(b_den), .frame_tick(b_tick)
`ifdef SEVEN_SEG_BRIGHTNESS_PWM_EN
    , .brightness(4'd15)
`endif
  );

`ifdef SEVEN_SEG_BRIGHTNESS_PWM_EN
  logic       c_en, c_tick, c_pend, c_rdy;
  logic [3:0] c_bri;
  logic [6:0] c_seg;
  logic [1:0] c_den;
  logic [0:0] c_addr;
  seven_seg_scan_ctrl #(.NUM_DIGITS(2), .DWELL(32), .BLANK(0), .CBITS(8)) dut_c (
    .clk(clk), .rst(rst), .en(c_en), .wr_valid(1'b0), .wr_ready(c_rdy),
    .wr_addr(c_addr), .wr_data(7'd0), .commit(1'b0), .commit_pending(c_pend),
    .segment(c_seg), .digit_en(c_den), .frame_tick(c_tick), .brightness(c_bri)
  );
`endif

  // One scanned cycle of the main DUT: advance the reference model, then compare.
  task automatic cyc(input string tag);
    logic       pend_old;
    int         p, slot, q;
    logic [6:0] es;
    logic [3:0] ed;
    logic       et;
    @(negedge clk);
    p = k % 40; slot = p / 10; q = p % 10;
    pend_old = m_pend;
    if (wr_valid && !pend_old) m_shadow[wr_addr] = wr_data;
    if (pend_old && p == 0) begin
      m_act  = m_shadow;
      m_pend = 1'b0;
    end else if (commit) begin
      m_pend = 1'b1;
    end
    es = (q >= 2) ? m_act[slot] : 7'd0;
    ed = (q >= 2) ? (4'b0001 << slot) : 4'b0000;
    et = (slot == 0) && (q == 2);
    checks++;
    if ({segment, digit_en, frame_tick, commit_pending, wr_ready} !== {es, ed, et, m_pend, !m_pend}) begin
      errors++;
      $display("FAIL %s k=%0d: got seg=%h den=%b tick=%b pend=%b rdy=%b, expected seg=%h den=%b tick=%b pend=%b rdy=%b",
               tag, k, segment, digit_en, frame_tick, commit_pending, wr_ready, es, ed, et, m_pend, !m_pend);
    end
    k++;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; wr_valid = 1'b0; commit = 1'b0; wr_addr = 2'd0; wr_data = 7'd0;
    b_en = 1'b0; b_wr_valid = 1'b0; b_commit = 1'b0; b_wr_addr = 2'd0; b_wr_data = 7'd0;
`ifdef SEVEN_SEG_BRIGHTNESS_PWM_EN
    c_en = 1'b0; c_bri = 4'd0; c_addr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if ({segment, digit_en, frame_tick, commit_pending, wr_ready} !== {7'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: got seg=%h den=%b tick=%b pend=%b rdy=%b, expected 00 0000 0 0 1",
               segment, digit_en, frame_tick, commit_pending, wr_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({segment, digit_en, frame_tick} !== {7'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL off_dark: got seg=%h den=%b tick=%b, expected 00 0000 0", segment, digit_en, frame_tick);
    end
  endtask

  task automatic test_scan_order();
    logic [6:0] pat [4];
    pat = '{7'h01, 7'h02, 7'h04, 7'h08};
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 2'(i); wr_data = pat[i];
      @(negedge clk);
    end
    wr_valid = 1'b0;
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    checks++;
    if ({commit_pending, wr_ready} !== 2'b10) begin
      errors++;
      $display("FAIL commit_set: got pend=%b rdy=%b, expected pend=1 rdy=0", commit_pending, wr_ready);
    end
    @(negedge clk);
    checks++;
    if ({commit_pending, wr_ready} !== 2'b01) begin
      errors++;
      $display("FAIL commit_off_apply: got pend=%b rdy=%b, expected pend=0 rdy=1", commit_pending, wr_ready);
    end
    m_shadow = pat; m_act = pat; m_pend = 1'b0;
    en = 1'b1; k = 0;
    while (k < 80) cyc("scan");
  endtask

  task automatic test_tear_free();
    while (k < 94) cyc("tear_pre");
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 7'h7F;
    cyc("tear_write");
    wr_valid = 1'b0; commit = 1'b1;
    cyc("tear_commit");
    commit = 1'b0;
    while (k < 100) cyc("tear_wait");
    commit = 1'b1;
    cyc("second_commit");
    commit = 1'b0;
    while (k < 105) cyc("tear_wait");
    wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 7'h55;
    cyc("write_while_pending");
    wr_valid = 1'b0;
    while (k < 120) cyc("tear_wait");
    commit = 1'b1;
    cyc("commit_on_wrap");
    commit = 1'b0;
    while (k < 165) cyc("tear_new_frame");
    commit = 1'b1;
    cyc("recommit");
    commit = 1'b0;
    while (k < 207) cyc("recommit_frame");
  endtask

  task automatic test_disable();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({segment, digit_en, frame_tick, commit_pending} !== {7'd0, 4'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL disable_dark c=%0d: got seg=%h den=%b tick=%b pend=%b, expected 00 0000 0 0",
                 i, segment, digit_en, frame_tick, commit_pending);
      end
    end
    en = 1'b1; k = 0;
    while (k < 45) cyc("reenable");
  endtask

  task automatic test_reset_mid();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({segment, digit_en, frame_tick, commit_pending, wr_ready} !== {7'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_async: got seg=%h den=%b tick=%b pend=%b rdy=%b, expected 00 0000 0 0 1",
               segment, digit_en, frame_tick, commit_pending, wr_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    m_shadow = '{default: 7'd0}; m_act = '{default: 7'd0}; m_pend = 1'b0; k = 0;
    while (k < 40) cyc("after_reset");
  endtask

  task automatic test_blank0_oob();
    logic [6:0] bp [4];
    int         slot;
    bp = '{7'h11, 7'h22, 7'h33, 7'h7F};
    b_wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_wr_addr = 2'(i); b_wr_data = bp[i];
      @(negedge clk);
    end
    b_wr_valid = 1'b0; b_commit = 1'b1;
    @(negedge clk);
    b_commit = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_pend, b_rdy} !== 2'b01) begin
      errors++;
      $display("FAIL b_commit_off: got pend=%b rdy=%b, expected pend=0 rdy=1", b_pend, b_rdy);
    end
    b_en = 1'b1;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      slot = (j % 12) / 4;
      checks++;
      if ({b_seg, b_den, b_tick} !== {bp[slot], 3'b001 << slot, (j % 12) == 0}) begin
        errors++;
        $display("FAIL blank0 j=%0d: got seg=%h den=%b tick=%b, expected seg=%h den=%b tick=%b",
                 j, b_seg, b_den, b_tick, bp[slot], 3'b001 << slot, (j % 12) == 0);
      end
    end
    b_en = 1'b0;
  endtask

`ifdef SEVEN_SEG_BRIGHTNESS_PWM_EN
  task automatic test_pwm();
    int on0, on1;
    on0 = 0; on1 = 0;
    c_bri = 4'd3; c_en = 1'b1;
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      if (j < 32) on0 += int'(c_den[0]);
      else        on1 += int'(c_den[1]);
      if (j == 31) c_bri = 4'd15;
    end
    checks++;
    if (on0 != 8) begin
      errors++;
      $display("FAIL pwm_b3: got on_cycles=%0d, expected 8", on0);
    end
    checks++;
    if (on1 != 32) begin
      errors++;
      $display("FAIL pwm_b15: got on_cycles=%0d, expected 32", on1);
    end
    c_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_scan_order();
    test_tear_free();
    test_disable();
    test_reset_mid();
    test_blank0_oob();
`ifdef SEVEN_SEG_BRIGHTNESS_PWM_EN
    test_pwm();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
